// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the IF/LS memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF        = 64;
  localparam int unsigned DATA_W_DEF        = 64;
  localparam int unsigned BE_W              = DATA_W_DEF / 8;
  localparam int unsigned MAX_LS_STREAK_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals around the arbiter.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  localparam int unsigned BeW = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [BeW-1:0]    ls_be;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BeW-1:0]    mem_be;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view: serves the core requesters and masters the memory port.
  modport master (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_arb_streak_counter.sv
// Counts consecutive LS grants taken while IF waits; forces IF to win at the limit.
module mem_port_arbiter_arb_streak_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LS_STREAK = MAX_LS_STREAK_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_if_req,
  input  logic i_if_gnt,
  input  logic i_ls_gnt,
  output logic o_force_if
);

  localparam int unsigned CntW = $clog2(MAX_LS_STREAK + 1);

  logic [CntW-1:0] r_streak;
  logic [CntW-1:0] w_streak_next;
  logic            w_at_max;

  assign w_at_max   = (r_streak == CntW'(MAX_LS_STREAK));
  assign o_force_if = i_if_req && w_at_max;

  always_comb begin
    w_streak_next = r_streak;
    if (i_if_gnt) begin
      w_streak_next = '0;
    end else if (i_ls_gnt) begin
      if (!i_if_req) begin
        w_streak_next = '0;
      end else if (!w_at_max) begin
        w_streak_next = r_streak + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else begin
      r_streak <= w_streak_next;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction in flight,
// and steers read data back to whichever requester owns the transaction.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned MAX_LS_STREAK = MAX_LS_STREAK_DEF
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.master bus
);

  localparam int unsigned BeW = DATA_W / 8;

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  owner_t            r_owner;
  logic              r_we;
  logic              r_kill;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BeW-1:0]    r_be;

  logic w_idle;
  logic w_force_if;
  logic w_if_win;
  logic w_if_gnt;
  logic w_ls_gnt;
  logic w_rd_done;
  logic w_kill_set;

  // Grants are gated by rst_n so nothing is accepted while reset is held.
  assign w_idle     = (r_state == IDLE) && rst_n;
  assign w_if_win   = bus.if_req && (!bus.ls_req || w_force_if);
  assign w_if_gnt   = w_idle && w_if_win;
  assign w_ls_gnt   = w_idle && bus.ls_req && !w_if_win;
  assign w_rd_done  = (r_state == RESP) && bus.mem_rvalid;
  assign w_kill_set = bus.if_flush && (r_owner == OWN_IF) &&
                      ((r_state == REQ) || (r_state == RESP));

  mem_port_arbiter_arb_streak_counter #(
    .MAX_LS_STREAK(MAX_LS_STREAK)
  ) u_streak (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_if_req  (bus.if_req),
    .i_if_gnt  (w_if_gnt),
    .i_ls_gnt  (w_ls_gnt),
    .o_force_if(w_force_if)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_if_gnt || w_ls_gnt) w_state_next = REQ;
      REQ:     if (bus.mem_gnt) w_state_next = r_we ? IDLE : RESP;
      RESP:    if (bus.mem_rvalid) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_IF;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_kill  <= 1'b0;
    end else begin
      if (w_if_gnt) begin
        r_owner <= OWN_IF;
        r_we    <= 1'b0;
        r_addr  <= bus.if_addr;
        r_wdata <= '0;
        r_be    <= '1;
      end else if (w_ls_gnt) begin
        r_owner <= OWN_LS;
        r_we    <= bus.ls_we;
        r_addr  <= bus.ls_addr;
        r_wdata <= bus.ls_wdata;
        r_be    <= bus.ls_be;
      end
      if (w_rd_done) begin
        r_kill <= 1'b0;
      end else if (w_kill_set) begin
        r_kill <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.if_gnt    = w_if_gnt;
    bus.ls_gnt    = w_ls_gnt;
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = '0;
    bus.ls_rvalid = 1'b0;
    bus.ls_rdata  = '0;
    bus.mem_req   = (r_state == REQ);
    bus.mem_we    = r_we;
    bus.mem_addr  = r_addr;
    bus.mem_wdata = r_wdata;
    bus.mem_be    = r_be;
    if (w_rd_done) begin
      if (r_owner == OWN_LS) begin
        bus.ls_rvalid = 1'b1;
        bus.ls_rdata  = bus.mem_rdata;
      end else if (!r_kill && !bus.if_flush) begin
        // A flush landing on the response cycle discards it too.
        bus.if_rvalid = 1'b1;
        bus.if_rdata  = bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, starvation, store, flush, reset.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the grant cycle; zero-wait memory, leaves mem_rvalid high in RESP.
  task automatic serve_read(input logic [63:0] data, input logic drop_reqs);
    tick();
    if (drop_reqs) begin
      bus.if_req   = 1'b0;
      bus.ls_req   = 1'b0;
      bus.if_flush = 1'b0;
    end
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    bus.if_req     = 1'b1;
    bus.if_addr    = '0;
    bus.if_flush   = 1'b0;
    bus.ls_req     = 1'b1;
    bus.ls_we      = 1'b0;
    bus.ls_addr    = '0;
    bus.ls_wdata   = '0;
    bus.ls_be      = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    #1;
    check("rst_if_gnt", bus.if_gnt, 0);
    check("rst_ls_gnt", bus.ls_gnt, 0);
    check("rst_mem_req", bus.mem_req, 0);
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h1000;
    @(negedge clk);
    check("f_if_gnt", bus.if_gnt, 1);
    check("f_ls_gnt", bus.ls_gnt, 0);
    check("f_req_c0", bus.mem_req, 0);
    tick();
    bus.if_req  = 1'b0;
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    check("f_req_c1", bus.mem_req, 1);
    check("f_addr", bus.mem_addr, 64'h1000);
    check("f_we", bus.mem_we, 0);
    check("f_be", bus.mem_be, 8'hFF);
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hDEAD_BEEF;
    @(negedge clk);
    check("f_if_rvalid", bus.if_rvalid, 1);
    check("f_if_rdata", bus.if_rdata, 64'hDEAD_BEEF);
    check("f_ls_rvalid", bus.ls_rvalid, 0);
    check("f_req_c2", bus.mem_req, 0);
    tick();
    bus.mem_rvalid = 1'b0;

    // Contention: LS first, IF in the cycle after ls_rvalid
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h1004;
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 64'h2000;
    bus.ls_be   = 8'hFF;
    @(negedge clk);
    check("c_ls_gnt", bus.ls_gnt, 1);
    check("c_if_gnt0", bus.if_gnt, 0);
    tick();
    bus.ls_req  = 1'b0;
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    check("c_ls_addr", bus.mem_addr, 64'h2000);
    check("c_if_gnt1", bus.if_gnt, 0);
    tick();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    check("c_ls_rvalid", bus.ls_rvalid, 1);
    check("c_ls_rdata", bus.ls_rdata, 64'h0123_4567_89AB_CDEF);
    check("c_if_rvalid", bus.if_rvalid, 0);
    check("c_if_gnt2", bus.if_gnt, 0);
    tick();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    check("c_if_gnt3", bus.if_gnt, 1);
    serve_read(64'h1111_2222, 1'b1);
    @(negedge clk);
    check("c_if_rdata", bus.if_rdata, 64'h1111_2222);
    tick();
    bus.mem_rvalid = 1'b0;

    // Starvation: four LS grants, then IF is forced, then LS again
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h5000;
    bus.ls_req  = 1'b1;
    bus.ls_addr = 64'h4000;
    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      check($sformatf("s_if_gnt%0d", r), bus.if_gnt, (r == 4) ? 1 : 0);
      check($sformatf("s_ls_gnt%0d", r), bus.ls_gnt, (r == 4) ? 0 : 1);
      serve_read(64'h100 + 64'(r), 1'b0);
      @(negedge clk);
      check($sformatf("s_rvalid%0d", r), (r == 4) ? bus.if_rvalid : bus.ls_rvalid, 1);
      tick();
      bus.mem_rvalid = 1'b0;
    end
    bus.if_req = 1'b0;
    bus.ls_req = 1'b0;

    // Store held stable over four REQ cycles
    bus.ls_req   = 1'b1;
    bus.ls_we    = 1'b1;
    bus.ls_addr  = 64'h3008;
    bus.ls_be    = 8'h0F;
    bus.ls_wdata = 64'h1122_3344_5566_7788;
    @(negedge clk);
    check("st_gnt", bus.ls_gnt, 1);
    tick();
    bus.ls_req   = 1'b0;
    bus.ls_we    = 1'b0;
    bus.ls_addr  = '0;
    bus.ls_be    = '0;
    bus.ls_wdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_gnt = 1'b1;
      @(negedge clk);
      check($sformatf("st_req%0d", i), bus.mem_req, 1);
      check($sformatf("st_we%0d", i), bus.mem_we, 1);
      check($sformatf("st_addr%0d", i), bus.mem_addr, 64'h3008);
      check($sformatf("st_wdata%0d", i), bus.mem_wdata, 64'h1122_3344_5566_7788);
      check($sformatf("st_be%0d", i), bus.mem_be, 8'h0F);
      tick();
    end
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    @(negedge clk);
    check("st_idle", bus.mem_req, 0);
    check("st_ls_rvalid", bus.ls_rvalid, 0);
    check("st_if_rvalid", bus.if_rvalid, 0);
    tick();
    bus.mem_rvalid = 1'b0;

    // Flush during RESP suppresses if_rvalid
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h6000;
    @(negedge clk);
    check("fl_gnt", bus.if_gnt, 1);
    tick();
    bus.if_req  = 1'b0;
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt  = 1'b0;
    bus.if_flush = 1'b1;
    @(negedge clk);
    check("fl_rv0", bus.if_rvalid, 0);
    tick();
    bus.if_flush = 1'b0;
    @(negedge clk);
    check("fl_rv1", bus.if_rvalid, 0);
    check("fl_resp", bus.mem_req, 0);
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hBAD0_BAD0;
    @(negedge clk);
    check("fl_rv2", bus.if_rvalid, 0);
    check("fl_rdata", bus.if_rdata, 0);
    check("fl_ls_rv", bus.ls_rvalid, 0);
    tick();
    bus.mem_rvalid = 1'b0;
    // Flush coinciding with a new grant does not kill it
    bus.if_req   = 1'b1;
    bus.if_addr  = 64'h6008;
    bus.if_flush = 1'b1;
    @(negedge clk);
    check("fl_gnt2", bus.if_gnt, 1);
    serve_read(64'h7777, 1'b1);
    @(negedge clk);
    check("fl_rv3", bus.if_rvalid, 1);
    check("fl_rdata2", bus.if_rdata, 64'h7777);
    tick();
    bus.mem_rvalid = 1'b0;

    // Async reset while in RESP
    bus.ls_req  = 1'b1;
    bus.ls_we   = 1'b0;
    bus.ls_addr = 64'h7000;
    bus.ls_be   = 8'hFF;
    @(negedge clk);
    check("r_ls_gnt", bus.ls_gnt, 1);
    tick();
    bus.ls_req  = 1'b0;
    bus.mem_gnt = 1'b1;
    tick();
    bus.mem_gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("r_mem_req", bus.mem_req, 0);
    check("r_mem_addr", bus.mem_addr, 0);
    check("r_mem_be", bus.mem_be, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'h99;
    @(negedge clk);
    check("r_ls_rv", bus.ls_rvalid, 0);
    check("r_if_rv", bus.if_rvalid, 0);
    check("r_ls_rdata", bus.ls_rdata, 0);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.if_req     = 1'b1;
    bus.if_addr    = 64'h8000;
    @(negedge clk);
    check("r_idle_gnt", bus.if_gnt, 1);
    check("r_idle_req", bus.mem_req, 0);
    tick();
    bus.if_req = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
